sad_addr_comparator: RTL and testbench
======================================

// Module: sad_addr_comparator
// PURPOSE
// - Loop-bound comparator for the SAD (sum of absolute differences) datapath.
// - Flags whether the current A/B memory address is still inside the block (AB_addr < LIMIT).
// - The SAD controller FSM uses comp to decide between another accumulate pass and finishing.
// - Also gives registered, last-address and loop-exit flags, so the controller can sample on its clock.
// PARAMETERS
// - ADDR_W   9     width of AB_addr; holds LIMIT itself, so the out-of-range state is visible.
// - LIMIT    256   exclusive upper bound. Legal range 1 .. 2**ADDR_W-1.
// PORTS
// - clk       in   1       system clock, rising edge.
// - rst_n     in   1       synchronous reset, active low.
// - AB_addr   in   ADDR_W  current SAD address counter value.
// - comp      out  1       combinational: 1 when AB_addr < LIMIT (unsigned).
// - comp_q    out  1       comp registered on clk.
// - last      out  1       combinational: 1 when AB_addr == LIMIT-1.
// - exit_p    out  1       registered one-cycle pulse on the comp_q 1->0 transition.
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low.
// - comp:
//   - Purely combinational, unsigned compare over the full ADDR_W bits.
//   - No clock or reset dependency; valid in the same delta as AB_addr changes.
//   - Driven even while rst_n=0.
// - last: combinational equality to LIMIT-1; independent of reset.
// - Registered outputs, updated on posedge clk:
//   - rst_n=0 -> comp_q=0, exit_p=0, internal prev_comp=0.
//   - rst_n=1 -> comp_q <= comp; exit_p <= comp_q & ~comp (1 cycle latency from comp).
//   - exit_p is high for exactly one cycle per fall of comp.
//   - No pulse if comp stays low, or if it was low out of reset.
// - Reset mid-operation:
//   - Clears comp_q and exit_p on that edge.
//   - The first post-reset cycle cannot produce exit_p, because comp_q restarts at 0.
// - Boundaries, LIMIT=256, ADDR_W=9:
//   - AB_addr=0 -> comp=1.
//   - AB_addr=255 -> comp=1, last=1.
//   - AB_addr=256 -> comp=0.
//   - AB_addr=511 -> comp=0.
// - Wrap-around is not handled here. The address counter owns overflow; a 511->0 wrap reasserts comp.
// - X/Z on AB_addr propagates to comp and last. No masking.
// - No latches. All registered state is reset by rst_n only.
// TESTING
// - Reset then addr sweep:
//   - rst_n=0 for 2 clk -> comp_q=0, exit_p=0.
//   - AB_addr=0 -> comp=1, last=0.
// - AB_addr=37 -> comp=1, last=0; next edge comp_q=1.
// - AB_addr=255 -> comp=1, last=1; next edge comp_q=1, exit_p=0.
// - AB_addr=256 after 255:
//   - comp=0 immediately.
//   - Next edge comp_q=0, exit_p=1.
//   - Following edge exit_p=0.
// - Hold AB_addr=256 for 5 clk -> exit_p stays 0.
//   - Then AB_addr=0 -> comp=1.
//   - rst_n=0 on the same edge -> comp_q=0.
// - Exhaustive 0..511: comp==(AB_addr<256) and last==(AB_addr==255) for every value.
//   - Re-run with LIMIT=100 -> 99 gives comp=1, last=1; 100 gives comp=0.

Source files
------------

// File: rtl/sad_addr_comparator_if.sv
`default_nettype none
// ============================================================================
// Module      : sad_addr_comparator_if
// Description : Address / flag bundle between the SAD address counter side
//               (master) and the loop-bound comparator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sad_addr_comparator_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] AB_addr;
  logic              comp;
  logic              comp_q;
  logic              last;
  logic              exit_p;

  // Counter / controller side: drives the address, consumes the flags.
  modport master (
    output AB_addr,
    input  comp,
    input  comp_q,
    input  last,
    input  exit_p
  );

  // Comparator side: consumes the address, produces the flags.
  modport slave (
    input  AB_addr,
    output comp,
    output comp_q,
    output last,
    output exit_p
  );
endinterface
`default_nettype wire

// File: rtl/sad_addr_comparator.sv
`default_nettype none
// ============================================================================
// Module      : sad_addr_comparator
// Description : Loop-bound comparator for the SAD datapath. Flags whether the
//               A/B address is still inside the block, whether it is on the
//               last address, and gives registered in-range / loop-exit flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_addr_comparator #(
  parameter int ADDR_W = 9,
  parameter int LIMIT  = 256
) (
  input  wire                   clk,
  input  wire                   rst_n,
  sad_addr_comparator_if.slave  bus
);

  // The address is wide enough to hold LIMIT itself, so both constants fit.
  localparam logic [ADDR_W-1:0] C_LIMIT = ADDR_W'(LIMIT);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(LIMIT - 1);

  logic w_comp;
  logic w_last;
  logic r_comp_q;
  logic r_exit_p;

  // Unsigned in-range and last-address decode; no clock or reset involvement.
  always_comb begin
    w_comp = (bus.AB_addr < C_LIMIT);
    w_last = (bus.AB_addr == C_LAST);
  end

  // r_comp_q doubles as the previous-cycle comp; a fall of comp while the
  // previous value was high produces a single-cycle exit pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_comp_q <= 1'b0;
      r_exit_p <= 1'b0;
    end else begin
      r_comp_q <= w_comp;
      r_exit_p <= r_comp_q & ~w_comp;
    end
  end

  assign bus.comp   = w_comp;
  assign bus.last   = w_last;
  assign bus.comp_q = r_comp_q;
  assign bus.exit_p = r_exit_p;

endmodule
`default_nettype wire

// File: tb/tb_sad_addr_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_addr_comparator
// Description : Self-checking bench for sad_addr_comparator (LIMIT=256 and
//               LIMIT=100 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_addr_comparator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sad_addr_comparator_if #(.ADDR_W(9)) if0 ();
  sad_addr_comparator_if #(.ADDR_W(9)) if1 ();

  sad_addr_comparator #(.ADDR_W(9), .LIMIT(256)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  sad_addr_comparator #(.ADDR_W(9), .LIMIT(100)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] addr;
    logic       exp_comp;
    logic       exp_last;
    logic       exp_comp_q;
    logic       exp_exit_p;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply an address away from the active edge, check the comb flags, then
  // check the registered flags just after the next rising edge.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    if0.AB_addr = v.addr;
    #1;
    chk($sformatf("comp[%0d]", v.addr), if0.comp, v.exp_comp);
    chk($sformatf("last[%0d]", v.addr), if0.last, v.exp_last);
    @(posedge clk);
    #1;
    chk($sformatf("comp_q[%0d]", v.addr), if0.comp_q, v.exp_comp_q);
    chk($sformatf("exit_p[%0d]", v.addr), if0.exit_p, v.exp_exit_p);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            addr  comp last comp_q exit_p (after next edge)
    vecs[0] = '{9'd0,   1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{9'd37,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{9'd255, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{9'd256, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{9'd256, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{9'd256, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{9'd256, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{9'd256, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{9'd256, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{9'd511, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with an in-range address: comp must still be driven.
    rst_n      = 1'b0;
    if0.AB_addr = 9'd0;
    if1.AB_addr = 9'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_comp_q", if0.comp_q, 1'b0);
    chk("rst_exit_p", if0.exit_p, 1'b0);
    chk("rst_comp_q_l100", if1.comp_q, 1'b0);
    chk("rst_comp_during_reset", if0.comp, 1'b1);
    chk("rst_last_during_reset", if0.last, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // Return in range, then reset on the same edge: comp_q must clear.
    @(negedge clk);
    if0.AB_addr = 9'd0;
    rst_n = 1'b0;
    #1;
    chk("wrap_comp", if0.comp, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_same_edge_comp_q", if0.comp_q, 1'b0);
    chk("rst_same_edge_exit_p", if0.exit_p, 1'b0);

    // Out of reset with comp low: no pulse may appear.
    @(negedge clk);
    rst_n = 1'b1;
    if0.AB_addr = 9'd256;
    @(posedge clk);
    #1;
    chk("post_rst_low_exit_p", if0.exit_p, 1'b0);
    chk("post_rst_low_comp_q", if0.comp_q, 1'b0);

    // Build comp_q=1, then fall while reset is asserted: reset wins.
    @(negedge clk);
    if0.AB_addr = 9'd10;
    @(posedge clk);
    #1;
    chk("pre_fall_comp_q", if0.comp_q, 1'b1);
    @(negedge clk);
    if0.AB_addr = 9'd300;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_on_fall_exit_p", if0.exit_p, 1'b0);
    chk("rst_on_fall_comp_q", if0.comp_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_post_rst_exit_p", if0.exit_p, 1'b0);

    // Exhaustive combinational sweep on both limits.
    for (int a = 0; a < 512; a++) begin
      @(negedge clk);
      if0.AB_addr = 9'(a);
      if1.AB_addr = 9'(a);
      #1;
      chk($sformatf("sweep_comp256[%0d]", a), if0.comp, (a < 256));
      chk($sformatf("sweep_last256[%0d]", a), if0.last, (a == 255));
      chk($sformatf("sweep_comp100[%0d]", a), if1.comp, (a < 100));
      chk($sformatf("sweep_last100[%0d]", a), if1.last, (a == 99));
    end

    // LIMIT=100 boundary with exit pulse.
    @(negedge clk);
    if1.AB_addr = 9'd99;
    #1;
    chk("l100_comp_99", if1.comp, 1'b1);
    chk("l100_last_99", if1.last, 1'b1);
    @(posedge clk);
    #1;
    chk("l100_comp_q_99", if1.comp_q, 1'b1);
    @(negedge clk);
    if1.AB_addr = 9'd100;
    #1;
    chk("l100_comp_100", if1.comp, 1'b0);
    chk("l100_last_100", if1.last, 1'b0);
    @(posedge clk);
    #1;
    chk("l100_exit_p_100", if1.exit_p, 1'b1);
    @(posedge clk);
    #1;
    chk("l100_exit_p_clear", if1.exit_p, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
